// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and serializer signal bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_i;
    logic [8*NUM_REQ-1:0] data_i;
    logic [NUM_REQ-1:0]   ack_o;
    logic                 err_o;
    logic                 busy_o;
    logic                 uart_enable_o;
    logic [7:0]           uart_data_o;
    logic                 uart_done_i;

    modport master (
        output req_i, data_i, uart_done_i,
        input  ack_o, err_o, busy_o, uart_enable_o, uart_data_o
    );

    modport slave (
        input  req_i, data_i, uart_done_i,
        output ack_o, err_o, busy_o, uart_enable_o, uart_data_o
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one uart_tx among NUM_REQ byte producers
// Optional frame watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int CLK_FREQ       = 100_000_000,
    parameter int BAUD_RATE      = 115_200,
    parameter int TIMEOUT_CYCLES = 12 * CLK_FREQ / BAUD_RATE
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("uart_tx_arbiter: NUM_REQ must be 2..16 and TIMEOUT_CYCLES at least 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_DONE, S_ACK} state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] ptr, grant, grant_next;
    logic [IDX_W:0]   cand;
    logic [7:0]       data_q, byte_next;
    logic             found, done_q, done_rise, timeout_hit;

    assign done_rise = bus.uart_done_i & ~done_q;

    // Scan from the pointer upward with wrap; first pending requester wins.
    always_comb begin
        found      = 1'b0;
        grant_next = ptr;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(i);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!found && bus.req_i[cand[IDX_W-1:0]]) begin
                found      = 1'b1;
                grant_next = cand[IDX_W-1:0];
            end
        end
        byte_next = '0;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (grant_next == IDX_W'(n)) begin
                byte_next = bus.data_i[8*n +: 8];
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (found) state_next = S_START;
            S_START:     state_next = S_WAIT_DONE;
            S_WAIT_DONE: if (done_rise || timeout_hit) state_next = S_ACK;
            S_ACK:       state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            ptr    <= '0;
            grant  <= '0;
            data_q <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= bus.uart_done_i;
            if (state == S_IDLE && found) begin
                grant  <= grant_next;
                data_q <= byte_next;
            end
            if (state == S_ACK) begin
                ptr <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);

    logic [TO_W-1:0] to_cnt;
    logic            err_q;

    assign timeout_hit = (state == S_WAIT_DONE) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Counter rests at zero outside WAIT_DONE, so it is clear on entry.
    // A done edge in the expiry cycle wins: the frame is reported as sent.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            to_cnt <= (state == S_WAIT_DONE) ? to_cnt + 1'b1 : '0;
            err_q  <= timeout_hit && !done_rise;
        end
    end

    assign bus.err_o = err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.err_o   = 1'b0;
`endif

    assign bus.busy_o        = (state != S_IDLE);
    assign bus.uart_enable_o = (state == S_START);
    assign bus.uart_data_o   = data_q;
    assign bus.ack_o         = (state == S_ACK) ? (NUM_REQ'(1) << grant) : '0;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(4)) bus();

    uart_tx_arbiter #(
        .NUM_REQ(4),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_i = '0;
        bus.uart_done_i = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    task automatic wait_enable(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.uart_enable_o) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // Returns at the negedge one cycle after the done rising edge.
    task automatic pulse_done();
        @(negedge clk);
        bus.uart_done_i = 1'b1;
        @(negedge clk);
        bus.uart_done_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_i = '0;
        bus.data_i = '0;
        bus.uart_done_i = 1'b0;
        step(2);
        checks++;
        if ({bus.busy_o, bus.uart_enable_o, bus.err_o, bus.ack_o, bus.uart_data_o} !== 15'h0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b en=%b err=%b ack=%b data=%h want all 0",
                     bus.busy_o, bus.uart_enable_o, bus.err_o, bus.ack_o, bus.uart_data_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        bus.req_i = 4'b0001;
        bus.data_i = 32'h0000_0055;
        @(negedge clk);
        checks++;
        if (bus.uart_enable_o !== 1'b1 || bus.uart_data_o !== 8'h55) begin
            errors++;
            $display("FAIL single_start: got en=%b data=%h want en=1 data=55", bus.uart_enable_o, bus.uart_data_o);
        end
        @(negedge clk);
        checks++;
        if (bus.uart_enable_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL single_en_width: got en=%b busy=%b want en=0 busy=1", bus.uart_enable_o, bus.busy_o);
        end
        pulse_done();
        checks++;
        if (bus.ack_o !== 4'b0001 || bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: got ack=%b err=%b want ack=0001 err=0", bus.ack_o, bus.err_o);
        end
        bus.req_i = '0;
        @(negedge clk);
        checks++;
        if (bus.ack_o !== 4'b0000 || bus.busy_o !== 1'b0 || bus.uart_data_o !== 8'h55) begin
            errors++;
            $display("FAIL single_idle: got ack=%b busy=%b data=%h want ack=0000 busy=0 data=55",
                     bus.ack_o, bus.busy_o, bus.uart_data_o);
        end
    endtask

    task automatic test_contention();
        bit seen;
        apply_reset();
        bus.req_i = 4'b0101;
        bus.data_i = 32'h0055_00AB;
        wait_enable(seen);
        checks++;
        if (!seen || bus.uart_data_o !== 8'hAB) begin
            errors++;
            $display("FAIL contention_first_byte: got seen=%b data=%h want seen=1 data=ab", seen, bus.uart_data_o);
        end
        pulse_done();
        checks++;
        if (bus.ack_o !== 4'b0001) begin
            errors++;
            $display("FAIL contention_first_ack: got %b want 0001", bus.ack_o);
        end
        bus.req_i = 4'b0100;
        @(negedge clk);
        checks++;
        if (bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL contention_gap: got busy=%b want 0", bus.busy_o);
        end
        @(negedge clk);
        checks++;
        if (bus.uart_enable_o !== 1'b1 || bus.uart_data_o !== 8'h55) begin
            errors++;
            $display("FAIL contention_second_byte: got en=%b data=%h want en=1 data=55", bus.uart_enable_o, bus.uart_data_o);
        end
        pulse_done();
        checks++;
        if (bus.ack_o !== 4'b0100) begin
            errors++;
            $display("FAIL contention_second_ack: got %b want 0100", bus.ack_o);
        end
        bus.req_i = '0;
    endtask

    task automatic test_fairness();
        bit       seen;
        int       exp_idx;
        logic [7:0] exp_byte;
        logic [3:0] exp_ack;
        apply_reset();
        bus.req_i = 4'b1111;
        bus.data_i = 32'h1312_1110;
        for (int f = 0; f < 6; f++) begin
            exp_idx  = f % 4;
            exp_byte = 8'(8'h10 + exp_idx);
            exp_ack  = 4'(1 << exp_idx);
            wait_enable(seen);
            checks++;
            if (!seen || bus.uart_data_o !== exp_byte) begin
                errors++;
                $display("FAIL fairness_byte[%0d]: got seen=%b data=%h want data=%h", f, seen, bus.uart_data_o, exp_byte);
            end
            pulse_done();
            checks++;
            if (bus.ack_o !== exp_ack) begin
                errors++;
                $display("FAIL fairness_ack[%0d]: got %b want %b", f, bus.ack_o, exp_ack);
            end
            @(negedge clk);
            checks++;
            if (bus.ack_o !== 4'b0000) begin
                errors++;
                $display("FAIL fairness_single_pulse[%0d]: got %b want 0000", f, bus.ack_o);
            end
        end
        bus.req_i = '0;
    endtask

    task automatic test_early_drop();
        bit seen;
        apply_reset();
        bus.req_i = 4'b0010;
        bus.data_i = 32'h0000_3C00;
        wait_enable(seen);
        checks++;
        if (!seen || bus.uart_data_o !== 8'h3C) begin
            errors++;
            $display("FAIL drop_byte: got seen=%b data=%h want data=3c", seen, bus.uart_data_o);
        end
        bus.req_i = '0;
        bus.data_i = 32'hFFFF_FFFF;
        step(2);
        checks++;
        if (bus.uart_data_o !== 8'h3C || bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL drop_hold: got data=%h busy=%b want data=3c busy=1", bus.uart_data_o, bus.busy_o);
        end
        pulse_done();
        checks++;
        if (bus.ack_o !== 4'b0010 || bus.uart_data_o !== 8'h3C) begin
            errors++;
            $display("FAIL drop_ack: got ack=%b data=%h want ack=0010 data=3c", bus.ack_o, bus.uart_data_o);
        end
        bus.data_i = '0;
    endtask

    task automatic test_reset_mid_frame();
        bit seen;
        bit saw_ack;
        apply_reset();
        bus.req_i = 4'b0001;
        bus.data_i = 32'h0000_0077;
        wait_enable(seen);
        @(negedge clk);
        rst = 1'b1;
        bus.req_i = '0;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.busy_o, bus.uart_enable_o, bus.err_o, bus.ack_o, bus.uart_data_o} !== 15'h0) begin
            errors++;
            $display("FAIL midreset_outputs: got busy=%b en=%b err=%b ack=%b data=%h want all 0",
                     bus.busy_o, bus.uart_enable_o, bus.err_o, bus.ack_o, bus.uart_data_o);
        end
        saw_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.ack_o !== 4'b0000) saw_ack = 1'b1;
        end
        checks++;
        if (saw_ack || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_ack: got saw_ack=%b busy=%b want 0 0", saw_ack, bus.busy_o);
        end
        bus.req_i = 4'b1000;
        bus.data_i = 32'hA500_0000;
        wait_enable(seen);
        checks++;
        if (!seen || bus.uart_data_o !== 8'hA5) begin
            errors++;
            $display("FAIL midreset_resume_byte: got seen=%b data=%h want data=a5", seen, bus.uart_data_o);
        end
        pulse_done();
        checks++;
        if (bus.ack_o !== 4'b1000) begin
            errors++;
            $display("FAIL midreset_resume_ack: got %b want 1000", bus.ack_o);
        end
        bus.req_i = '0;
    endtask

`ifdef UART_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit seen;
        apply_reset();
        bus.req_i = 4'b0001;
        bus.data_i = 32'h0000_00C3;
        wait_enable(seen);
        step(50);
        checks++;
        if (bus.ack_o !== 4'b0000 || bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: got ack=%b busy=%b want ack=0000 busy=1", bus.ack_o, bus.busy_o);
        end
        @(negedge clk);
        checks++;
        if (bus.ack_o !== 4'b0001 || bus.err_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_fire: got ack=%b err=%b want ack=0001 err=1", bus.ack_o, bus.err_o);
        end
        bus.req_i = '0;
        @(negedge clk);
        checks++;
        if (bus.err_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got err=%b busy=%b want 0 0", bus.err_o, bus.busy_o);
        end
    endtask
`else
    task automatic test_done_level();
        bit seen;
        bit saw_ack;
        apply_reset();
        bus.uart_done_i = 1'b1;
        step(2);
        checks++;
        if (bus.busy_o !== 1'b0 || bus.ack_o !== 4'b0000) begin
            errors++;
            $display("FAIL done_idle_ignored: got busy=%b ack=%b want 0 0000", bus.busy_o, bus.ack_o);
        end
        bus.req_i = 4'b0001;
        bus.data_i = 32'h0000_005A;
        wait_enable(seen);
        saw_ack = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.ack_o !== 4'b0000) saw_ack = 1'b1;
        end
        checks++;
        if (saw_ack || bus.busy_o !== 1'b1 || bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL done_level_wait: got saw_ack=%b busy=%b err=%b want 0 1 0", saw_ack, bus.busy_o, bus.err_o);
        end
        bus.uart_done_i = 1'b0;
        @(negedge clk);
        pulse_done();
        checks++;
        if (bus.ack_o !== 4'b0001 || bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL done_level_ack: got ack=%b err=%b want 0001 0", bus.ack_o, bus.err_o);
        end
        bus.req_i = '0;
    endtask
`endif

    initial begin
        bus.req_i = '0;
        bus.data_i = '0;
        bus.uart_done_i = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_early_drop();
        test_reset_mid_frame();
`ifdef UART_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_done_level();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer between NUM_REQ byte-producing requesters.
- Arbitrates pending requests round-robin and latches the granted byte.
- Issues a single-cycle start pulse to the serializer, waits for its done indication, then acknowledges the requester.
- Sits between on-chip producers (status/debug/logging sources) and the uart_tx instance; same clock domain as the serializer.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- CLK_FREQ, 100_000_000, system clock frequency in Hz; used only for the timeout calculation.
- BAUD_RATE, 115_200, serializer baud rate; used only for the timeout calculation.
- TIMEOUT_CYCLES, 12*CLK_FREQ/BAUD_RATE (10416 at defaults), watchdog limit in clk cycles for one frame.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_i  input  NUM_REQ  per-requester request level; held high with data stable until the matching ack_o.
- data_i  input  8*NUM_REQ  packed bytes; requester n occupies data_i[8n+7:8n].
- ack_o  output  NUM_REQ  one-hot, one-cycle pulse; the byte of that requester has been sent (or abandoned, see err_o).
- err_o  output  1  one-cycle pulse coincident with ack_o when the frame timed out.
- busy_o  output  1  high in every state except IDLE.
- uart_enable_o  output  1  one-cycle start pulse to uart_tx enable input.
- uart_data_o  output  8  byte to uart_tx data input; held stable from the enable pulse until ACK.
- uart_done_i  input  1  uart_tx done output; pulse or level, rising edge detected internally.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Round-robin pointer 0; done edge-detect register 0; timeout counter 0.
- Reset mid-operation: same values on the next edge. Any frame in flight is abandoned with no ack. uart_tx shares rst.
- IDLE:
  - If req_i != 0 at an edge, select the first set bit scanning from the pointer upward with wrap: ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1.
  - Register the grant index (clog2(NUM_REQ) bits), latch that requester's byte into uart_data_o, go to START.
- START: uart_enable_o = 1 for exactly this cycle; go to WAIT_DONE. Latency from the req-sampling edge to the enable cycle is 1 clock.
- WAIT_DONE:
  - Clear the timeout counter on entry.
  - done_rise = uart_done_i & ~done_q, where done_q is registered every cycle.
  - On done_rise, go to ACK.
  - A done edge in START or IDLE is ignored.
- ACK:
  - ack_o[grant] = 1 for one cycle.
  - Pointer = grant+1, wrapping to 0 at NUM_REQ.
  - Go to IDLE.
  - Consecutive frames are separated by ACK plus at least one IDLE cycle.
- req_i deasserted by a requester after grant: frame completes and ack is still issued (no abort).
- req_i still high in the cycle after ack: treated as a new request. Fairness is via the pointer, so other pending requesters are served first.
- data_i changes after grant: ignored; the latched byte is sent.
- Simultaneous requests: pointer order decides; no starvation. Worst-case wait is NUM_REQ-1 frames.
- uart_data_o keeps its last value in IDLE; it is not cleared.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN
- Defined:
  - In WAIT_DONE, a counter increments each cycle.
  - When it reaches TIMEOUT_CYCLES-1 without done_rise, go to ACK and pulse err_o with ack_o.
  - If done_rise and timeout occur in the same cycle, done wins and err_o stays 0.
- Not defined:
  - No counter logic; err_o tied 0.
  - WAIT_DONE waits indefinitely for done_rise.

Test Plan:
- Single request: rst high 2 cycles, then req_i=4'b0001, byte0=8'h55.
  - uart_enable_o high exactly one cycle, 1 clock after the req-sampling edge, with uart_data_o=8'h55.
  - After uart_tx done rises, ack_o=4'b0001 for one cycle.
  - Serial line shows 0x55.
- Contention: req_i=4'b0101 simultaneously, byte0=8'hAB, byte2=8'h55.
  - Frames sent 0xAB then 0x55; ack_o order 0001 then 0100.
  - busy_o low at least one cycle between frames.
- Fairness: req_i=4'b1111 held continuously, bytes 8'h10..8'h13.
  - Grant order 0,1,2,3,0,1 across six frames.
  - Exactly one ack pulse per frame.
- Early drop: req1 granted with byte 8'h3C, then req_i cleared and data_i changed mid-frame.
  - 0x3C transmitted unaltered.
  - ack_o=4'b0010 still pulsed.
- Reset mid-frame: rst asserted for one cycle during WAIT_DONE.
  - Next cycle: state IDLE, all outputs 0, no ack.
  - Subsequent req3 with 8'hA5 is granted and sent normally.
- Timeout (UART_ARB_TIMEOUT_EN defined, stub uart_done_i=0, TIMEOUT_CYCLES=50):
  - ack_o and err_o pulse together 50 cycles after WAIT_DONE entry.
  - With the macro undefined, busy_o stays high indefinitely.
